elevator_queue_server: RTL
==========================

// Module: elevator_queue_server
// PURPOSE
//  Consumer/reader end of the 16x4 floor-request queue RAM. Reads the queue head (slot 0), drives the car
//  one floor at a time toward it, holds the door open, then pops the entry with a one-cycle shift pulse.
//  Sits between the request queue RAM and the cabin/display logic; it never writes request data.
//  Slot encoding: 4'd0 = empty slot, 4'd1..4'd15 = floor codes.
// PARAMETERS
//  MOVE_CYCLES    4   clock cycles per one-floor step (>=1)
//  DOOR_CYCLES    3   cycles porta_aberta stays high per stop (>=1)
//  ANDAR_INICIAL  1   floor code loaded on reset (1..15)
// PORTS
//  clk           in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-high
//  enable        in   1  1 = car may start/continue travel
//  q             in   4  queue RAM read data at addr (head entry)
//  addr          out  4  queue RAM read address; constant 4'd0
//  shift         out  1  one-cycle pop pulse to queue RAM
//  andar_atual   out  4  current floor code
//  alvo          out  4  target floor latched from head
//  sobe          out  1  moving up
//  desce         out  1  moving down
//  porta_aberta  out  1  door open
//  ocupado       out  1  state != IDLE
//  atendidos     out  8  served-request count, wraps 255->0
//  estado        out  3  state code for debug
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, andar_atual=ANDAR_INICIAL, alvo=0, move/door counters=0.
//    All 1-bit outputs=0; atendidos=0.
//  States (estado code): IDLE=0, MOVING=1, DOOR=2, POP=3, SETTLE=4. All outputs are registered.
//  IDLE:
//    - q!=0 && enable at an edge: alvo<=q, ->MOVING.
//    - Otherwise stay.
//  MOVING (each cycle; alvo<=q, head is re-sampled so inserts at slot 0 retarget the car):
//    - q==0 (queue cleared): ->IDLE, sobe/desce cleared.
//    - q==andar_atual: ->DOOR, move counter cleared, sobe=desce=0.
//    - q>andar_atual: sobe=1. q<andar_atual: desce=1.
//    - While enable=1 the move counter increments. When it reaches MOVE_CYCLES-1, andar_atual
//      steps +/-1 and the counter clears.
//    - Direction reversal clears the move counter.
//    - enable=0 freezes the counter and andar_atual; sobe/desce hold.
//  DOOR: porta_aberta=1 for exactly DOOR_CYCLES cycles (enable ignored), then ->POP.
//  POP: shift=1 for exactly one cycle; atendidos+1; ->SETTLE.
//  SETTLE: one cycle so the RAM shift lands before the head is read again; ->IDLE.
//  Direction outputs: sobe and desce are never both 1; both are 0 outside MOVING.
//  Floor bounds: andar_atual stays within 1..15 and never steps past alvo.
//  Head already at the current floor: IDLE->MOVING (one cycle, no step)->DOOR.
//  Pop limit: shift is asserted at most once per served entry, and never while the queue was
//    observed empty.
//  Concurrent RAM writes (weT/fit) in the same cycle as shift are the RAM's concern.
//  Reset mid-operation aborts all activity; no shift is issued.
// TESTING
//  1. reset, q=0 for 50 cycles -> stays IDLE; shift never 1; ocupado=0; andar_atual=1.
//  2. q=3 from floor 1 (MOVE=4, DOOR=3) -> sobe=1; andar 2 after 4 cycles, 3 after 8;
//     porta_aberta 3 cycles; one shift pulse; atendidos=1.
//  3. q=1 at floor 1 -> no sobe/desce; door 3 cycles; one shift pulse.
//  4. heading to 5 from 1, head changes to 2 at floor 1 -> stops at 2, door, pop;
//     then continues to the next head.
//  5. enable=0 for 10 cycles mid-step -> andar_atual and counter frozen;
//     resumes with the remaining cycles once enable=1.
//  6. reset asserted during DOOR -> outputs at reset values the same cycle; no shift issued.

Source files
------------

// File: rtl/elevator_queue_server.sv
// elevator_queue_server
// Reader side of the 16x4 floor-request queue. It follows the head entry (slot 0),
// steps the car one floor at a time toward it, holds the door open, then pops the
// entry with a single shift pulse. Request data is only ever read here, never written.
// Every output comes straight from a flop.
module elevator_queue_server #(
    parameter int MOVE_CYCLES   = 4,
    parameter int DOOR_CYCLES   = 3,
    parameter int ANDAR_INICIAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] q,
    output logic [3:0] addr,
    output logic       shift,
    output logic [3:0] andar_atual,
    output logic [3:0] alvo,
    output logic       sobe,
    output logic       desce,
    output logic       porta_aberta,
    output logic       ocupado,
    output logic [7:0] atendidos,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVING = 3'd1,
        DOOR   = 3'd2,
        POP    = 3'd3,
        SETTLE = 3'd4
    } state_t;

    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_CYCLES - 1);
    localparam logic [3:0]    FLOOR_INIT = 4'(ANDAR_INICIAL);

    state_t        state_q, state_d;
    logic [3:0]    andar_q, andar_d;
    logic [3:0]    alvo_q, alvo_d;
    logic [MW-1:0] moveCnt_q, moveCnt_d;
    logic [DW-1:0] doorCnt_q, doorCnt_d;
    logic          sobe_q, sobe_d;
    logic          desce_q, desce_d;
    logic          porta_q, porta_d;
    logic          shift_q, shift_d;
    logic          ocupado_q, ocupado_d;
    logic [7:0]    atend_q, atend_d;

    logic headValid;
    logic atHead;
    logic goUp;
    logic reversal;

    // The head is an empty slot when it reads 0; the car is at the head when the codes match.
    assign headValid = (q != 4'd0);
    assign atHead    = (q == andar_q);
    assign goUp      = (q > andar_q);
    assign reversal  = (goUp && desce_q) || (!goUp && sobe_q);

    // Register all state and all outputs; reset aborts everything, including any pending pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            andar_q   <= FLOOR_INIT;
            alvo_q    <= 4'd0;
            moveCnt_q <= '0;
            doorCnt_q <= '0;
            sobe_q    <= 1'b0;
            desce_q   <= 1'b0;
            porta_q   <= 1'b0;
            shift_q   <= 1'b0;
            ocupado_q <= 1'b0;
            atend_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            andar_q   <= andar_d;
            alvo_q    <= alvo_d;
            moveCnt_q <= moveCnt_d;
            doorCnt_q <= doorCnt_d;
            sobe_q    <= sobe_d;
            desce_q   <= desce_d;
            porta_q   <= porta_d;
            shift_q   <= shift_d;
            ocupado_q <= ocupado_d;
            atend_q   <= atend_d;
        end
    end

    // Choose the next state: MOVING re-checks the head every cycle so the queue can retarget the car.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (headValid && enable) state_d = MOVING;
            end
            MOVING: begin
                if (!headValid)  state_d = IDLE;
                else if (atHead) state_d = DOOR;
            end
            DOOR: begin
                if (doorCnt_q == DOOR_LAST) state_d = POP;
            end
            POP:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output values for the coming cycle; direction flags default low so they only live in MOVING.
    always_comb begin
        andar_d   = andar_q;
        alvo_d    = alvo_q;
        moveCnt_d = moveCnt_q;
        doorCnt_d = doorCnt_q;
        sobe_d    = 1'b0;
        desce_d   = 1'b0;
        porta_d   = 1'b0;
        shift_d   = 1'b0;
        atend_d   = atend_q;
        ocupado_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                moveCnt_d = '0;
                if (headValid && enable) alvo_d = q;
            end
            MOVING: begin
                alvo_d = q;
                if (!headValid) begin
                    moveCnt_d = '0;
                end else if (atHead) begin
                    moveCnt_d = '0;
                    doorCnt_d = '0;
                    porta_d   = 1'b1;
                end else if (!enable) begin
                    sobe_d  = sobe_q;
                    desce_d = desce_q;
                end else begin
                    sobe_d  = goUp;
                    desce_d = !goUp;
                    if (reversal) begin
                        moveCnt_d = '0;
                    end else if (moveCnt_q == MOVE_LAST) begin
                        moveCnt_d = '0;
                        andar_d   = goUp ? (andar_q + 4'd1) : (andar_q - 4'd1);
                    end else begin
                        moveCnt_d = moveCnt_q + MW'(1);
                    end
                end
            end
            DOOR: begin
                if (doorCnt_q == DOOR_LAST) begin
                    shift_d = 1'b1;
                    atend_d = atend_q + 8'd1;
                end else begin
                    doorCnt_d = doorCnt_q + DW'(1);
                    porta_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign addr         = 4'd0;
    assign shift        = shift_q;
    assign andar_atual  = andar_q;
    assign alvo         = alvo_q;
    assign sobe         = sobe_q;
    assign desce        = desce_q;
    assign porta_aberta = porta_q;
    assign ocupado      = ocupado_q;
    assign atendidos    = atend_q;
    assign estado       = state_q;

endmodule
